// File: rtl/fluid_ctrl_pkg.sv
// Shared types and defaults for the fluid split sequencer.
// Holds the sequencer state enum, the default settle time and the dose word.
package fluid_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ROUTE,
      ST_FLOW,
      ST_DRAIN,
      ST_DONE
   } state_e;

   localparam int SETTLE_DEF = 8;
   localparam int DOSE_W_DEF = 16;

   typedef logic [DOSE_W_DEF-1:0] dose_t;

endpackage

// File: rtl/valve_timer.sv
// Loadable down-counter timing the settle, flow and drain phases.
// Ports: clk, rst_n (sync, low), load/load_val in; value, expire (value==1) out.
module valve_timer
   import fluid_ctrl_pkg::*;
#(
   parameter int W = DOSE_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         expire
);

   logic [W-1:0] cnt_q, cnt_d;

   // Holds at zero once run out, so it can never wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value  = cnt_q;
   assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/fluid_split_sequencer.sv
// Routes one inlet stream into one of N_OUT outlets with break-before-make timing.
// Ports: req_* command handshake, abort, valve_in/valve_out drives, busy, done_*/err_pulse status.
module fluid_split_sequencer
   import fluid_ctrl_pkg::*;
#(
   parameter int N_OUT         = 4,
   parameter int DEST_W        = $clog2(N_OUT),
   parameter int DOSE_W        = DOSE_W_DEF,
   parameter int SETTLE_CYCLES = SETTLE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DEST_W-1:0] req_dest,
   input  logic [DOSE_W-1:0] req_dose,
   input  logic              abort,
   output logic              valve_in,
   output logic [N_OUT-1:0]  valve_out,
   output logic              busy,
   output logic              done_pulse,
   output logic [DEST_W-1:0] done_dest,
   output logic              done_aborted,
   output logic              err_pulse
);

   localparam int SW    = $clog2(SETTLE_CYCLES + 1);
   localparam int CNT_W = (DOSE_W > SW) ? DOSE_W : SW;

   state_e            state_q, state_d;
   logic [DEST_W-1:0] dest_q, dest_d;
   logic [DOSE_W-1:0] dose_q, dose_d;
   logic              abt_q, abt_d;
   logic              err_q, err_d;
   logic [DEST_W-1:0] ddest_q, ddest_d;
   logic              dabt_q, dabt_d;

   logic              ld;
   logic [CNT_W-1:0]  ld_val;
   logic [CNT_W-1:0]  cnt_val;
   logic              cnt_exp;
   logic              req_ok;
   logic [N_OUT-1:0]  dest_oh;

   valve_timer #(.W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ld),
      .load_val (ld_val),
      .value    (cnt_val),
      .expire   (cnt_exp)
   );

   assign req_ok = (req_dose != '0) &&
                   (32'(req_dest) < 32'(N_OUT));

   always_comb begin
      state_d = state_q;
      dest_d  = dest_q;
      dose_d  = dose_q;
      abt_d   = abt_q;
      err_d   = 1'b0;
      ddest_d = ddest_q;
      dabt_d  = dabt_q;
      ld      = 1'b0;
      ld_val  = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_ok) begin
                  state_d = ST_ROUTE;
                  dest_d  = req_dest;
                  dose_d  = req_dose;
                  abt_d   = 1'b0;
                  ld      = 1'b1;
                  ld_val  = CNT_W'(SETTLE_CYCLES);
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_ROUTE, ST_FLOW: begin
            // Abort wins over phase expiry: always drain out.
            if (abort) begin
               state_d = ST_DRAIN;
               abt_d   = 1'b1;
               ld      = 1'b1;
               ld_val  = CNT_W'(SETTLE_CYCLES);
            end else if (cnt_exp) begin
               ld = 1'b1;
               if (state_q == ST_ROUTE) begin
                  state_d = ST_FLOW;
                  ld_val  = CNT_W'(dose_q);
               end else begin
                  state_d = ST_DRAIN;
                  ld_val  = CNT_W'(SETTLE_CYCLES);
               end
            end
         end
         ST_DRAIN: begin
            if (cnt_exp) begin
               state_d = ST_DONE;
               ddest_d = dest_q;
               dabt_d  = abt_q;
               ld      = 1'b1;
            end
         end
         ST_DONE: begin
            // Counter was cleared on entry; DONE lasts one cycle.
            if (cnt_val == '0) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         dest_q  <= '0;
         dose_q  <= '0;
         abt_q   <= 1'b0;
         err_q   <= 1'b0;
         ddest_q <= '0;
         dabt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dest_q  <= dest_d;
         dose_q  <= dose_d;
         abt_q   <= abt_d;
         err_q   <= err_d;
         ddest_q <= ddest_d;
         dabt_q  <= dabt_d;
      end
   end

   assign dest_oh = N_OUT'(1) << dest_q;

   assign valve_out = (state_q == ST_ROUTE ||
                       state_q == ST_FLOW  ||
                       state_q == ST_DRAIN) ? dest_oh : '0;

   assign valve_in     = (state_q == ST_FLOW);
   assign busy         = (state_q != ST_IDLE);
   assign req_ready    = (state_q == ST_IDLE);
   assign done_pulse   = (state_q == ST_DONE);
   assign done_dest    = ddest_q;
   assign done_aborted = dabt_q;
   assign err_pulse    = err_q;

endmodule

// File: doc/fluid_split_sequencer.md
Name: fluid_split_sequencer

Overview:
- Valve-timing controller for the opposite direction of the diffusion-mixer netlists: it takes one inlet stream and doses it into one of N outlet channels. In a mixer, many fluids flow into one outlet; here, one fluid is routed out to many.
- Sits between the host command interface and the pneumatic valve drivers of the split manifold.
- Guarantees break-before-make routing: the outlet valve is opened before the inlet and closed after it, with a timed settle and drain around each dose.

Parameters:
- N_OUT, 4, number of outlet channels (2..16).
- DEST_W, $clog2(N_OUT), width of the destination index.
- DOSE_W, 16, width of the dose length in clock cycles.
- SETTLE_CYCLES, 8, outlet settle/drain time in cycles (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  dose request valid.
- req_ready  out  1  controller can accept a request.
- req_dest  in  DEST_W  outlet index.
- req_dose  in  DOSE_W  inlet-open time in cycles.
- abort  in  1  level; terminates the current dose early.
- valve_in  out  1  inlet valve open.
- valve_out  out  N_OUT  outlet valves, one-hot or zero.
- busy  out  1  a dose sequence is in progress.
- done_pulse  out  1  one-cycle completion strobe.
- done_dest  out  DEST_W  outlet of the completed dose; holds its value until the next done.
- done_aborted  out  1  completed dose was cut short; valid with done_pulse.
- err_pulse  out  1  one-cycle strobe flagging a rejected request.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset values: state IDLE, valve_in=0, valve_out=0, busy=0, req_ready=1, done_pulse=0, done_dest=0, done_aborted=0, err_pulse=0, all counters 0.
- Reset mid-dose: all valves close on the next edge, with no drain phase.
- Handshake:
  - Transfer occurs when req_valid && req_ready.
  - req_ready = (state==IDLE); it is registered.
  - req_dest and req_dose are captured at the transfer edge.
- Request rejection: if req_dose==0 or req_dest≥N_OUT at transfer:
  - err_pulse=1 in the next cycle;
  - no valve activity, and the state stays IDLE (ready remains 1).
- FSM:
  - IDLE → ROUTE on a valid accepted request.
  - ROUTE: valve_out[dest]=1, valve_in=0, busy=1, for exactly SETTLE_CYCLES cycles; then → FLOW.
  - FLOW: valve_out[dest]=1, valve_in=1, for exactly req_dose cycles; then → DRAIN.
  - DRAIN: valve_out[dest]=1, valve_in=0, for exactly SETTLE_CYCLES cycles; then → DONE.
  - DONE: all valves 0, done_pulse=1, done_dest=dest, busy=1, ready=0, for one cycle; then → IDLE.
- Latency:
  - First cycle after the accept edge is ROUTE.
  - done_pulse is high in cycle accept+2·SETTLE_CYCLES+req_dose+1.
  - Next accept is possible one cycle after DONE.
- Abort:
  - Sampled every cycle.
  - In ROUTE or FLOW: the next cycle enters DRAIN (valve_in drops at that edge), and done_aborted is set.
  - Ignored in IDLE, DRAIN and DONE. A held abort does not block new requests.
- Invariants (assert in the bench):
  - $onehot0(valve_out) always holds.
  - valve_in implies a nonzero valve_out.
  - valve_out never changes while valve_in=1.
- Counter: one shared down-counter of width max(DOSE_W, $clog2(SETTLE_CYCLES+1)). It loads at each state entry and the state advances when it reaches 1. No wrap-around is possible, because a dose of 0 is rejected.

Decomposition:
- Shared package fluid_ctrl_pkg holds:
  - the state enum (IDLE, ROUTE, FLOW, DRAIN, DONE);
  - the default SETTLE_CYCLES constant;
  - a typedef for the dose word.
- One sub-module, valve_timer: a loadable down-counter with load, value and expire outputs, reused for the settle, flow and drain phases.

Test Plan:
- Basic dose: SETTLE=8, dest=2, dose=5 → valve_out=0100 for 21 cycles; valve_in high for cycles 9–13 after accept; done_pulse at accept+22 with done_dest=2, done_aborted=0.
- Zero dose: dose=0, dest=1 → err_pulse at accept+1; valve_out stays 0; req_ready stays 1.
- Out-of-range destination: N_OUT=3, dest=3, dose=4 → err_pulse; no valve activity.
- Abort in FLOW: dest=0, dose=100, abort pulsed at the 3rd FLOW cycle → valve_in low next cycle; 8 drain cycles follow; done_pulse with done_aborted=1.
- Back-to-back requests: req_valid held with dest 0 then dest 3 → req_ready low throughout the first sequence; second accept occurs one cycle after done_pulse; valve_out never shows 1001.
- Reset mid-FLOW: rst_n=0 for one edge during FLOW → all outputs at reset values on the next cycle; req_ready=1.
